// File: rtl/dist_sq_if.sv
// Request/result bundle for the squared-distance unit.
// master drives the coordinates and start; slave returns status and result.
interface dist_sq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] x1;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] x2;
   logic [WIDTH-1:0] y2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dist_sq;
   logic             ovf;

   modport master (
      output start, x1, y1, x2, y2,
      input  busy, done, dist_sq, ovf
   );

   modport slave (
      input  start, x1, y1, x2, y2,
      output busy, done, dist_sq, ovf
   );
endinterface

// File: rtl/dist_sq.sv
// Saturating squared distance (x1-x2)^2 + (y1-y2)^2 in signed fixed point, squares via serial shift-add.
// Optional macro DIST_SQ_ROUND_EN: round half up before dropping FRAC_WIDTH bits (default truncates).
module dist_sq #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FRAC_WIDTH = 30
) (
   input  logic     clk,
   input  logic     rst,
   dist_sq_if.slave bus
);

   localparam int unsigned MW = WIDTH + 1;
   localparam int unsigned PW = 2 * WIDTH + 2;
   localparam int unsigned SW = PW + 1;
   localparam int unsigned CW = $clog2(MW + 1);

`ifdef DIST_SQ_ROUND_EN
   localparam logic [SW-1:0] RND = SW'(1) << (FRAC_WIDTH - 1);
`else
   localparam logic [SW-1:0] RND = '0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SUB   = 3'd1,
      MUL_X = 3'd2,
      MUL_Y = 3'd3,
      SUM   = 3'd4,
      DONE  = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
   logic [MW-1:0]    mag_y_q, mag_y_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [MW-1:0]    mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    prod_x_q, prod_x_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] dist_q, dist_d;
   logic             ovf_q, ovf_d;

   logic [MW-1:0]    dx_c, dy_c, mag_x_c, mag_y_c;
   logic [PW-1:0]    acc_sum_c;
   logic [SW-1:0]    sq_x_c, sq_y_c, sum_c;
   logic             sat_c;

   // Datapath terms: wide differences, magnitudes, next partial sum, scaled total.
   always_comb begin
      dx_c      = {x1_q[WIDTH-1], x1_q} - {x2_q[WIDTH-1], x2_q};
      dy_c      = {y1_q[WIDTH-1], y1_q} - {y2_q[WIDTH-1], y2_q};
      mag_x_c   = dx_c[MW-1] ? (~dx_c + MW'(1)) : dx_c;
      mag_y_c   = dy_c[MW-1] ? (~dy_c + MW'(1)) : dy_c;
      acc_sum_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      sq_x_c    = (SW'(prod_x_q) + RND) >> FRAC_WIDTH;
      sq_y_c    = (SW'(acc_q) + RND) >> FRAC_WIDTH;
      sum_c     = sq_x_c + sq_y_c;
      sat_c     = |sum_c[SW-1:WIDTH];
   end

   // Next-state and register updates.
   always_comb begin
      state_d  = state_q;
      x1_d     = x1_q;
      y1_d     = y1_q;
      x2_d     = x2_q;
      y2_d     = y2_q;
      mag_y_d  = mag_y_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      prod_x_d = prod_x_q;
      cnt_d    = cnt_q;
      dist_d   = dist_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               x1_d    = bus.x1;
               y1_d    = bus.y1;
               x2_d    = bus.x2;
               y2_d    = bus.y2;
               state_d = SUB;
            end
         end
         SUB: begin
            mcand_d  = PW'(mag_x_c);
            mplier_d = mag_x_c;
            mag_y_d  = mag_y_c;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL_X;
         end
         MUL_X, MUL_Y: begin
            acc_d    = acc_sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH)) begin
               cnt_d = '0;
               if (state_q == MUL_X) begin
                  // x product parked; multiplier reloaded with |dy|.
                  prod_x_d = acc_sum_c;
                  acc_d    = '0;
                  mcand_d  = PW'(mag_y_q);
                  mplier_d = mag_y_q;
                  state_d  = MUL_Y;
               end else begin
                  state_d  = SUM;
               end
            end
         end
         SUM: begin
            dist_d  = sat_c ? '1 : sum_c[WIDTH-1:0];
            ovf_d   = sat_c;
            state_d = DONE;
         end
         DONE: begin
            acc_d    = '0;
            prod_x_d = '0;
            mcand_d  = '0;
            mplier_d = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         x1_q     <= '0;
         y1_q     <= '0;
         x2_q     <= '0;
         y2_q     <= '0;
         mag_y_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         prod_x_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dist_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         x2_q     <= x2_d;
         y2_q     <= y2_d;
         mag_y_q  <= mag_y_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         prod_x_q <= prod_x_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dist_q   <= dist_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.dist_sq = dist_q;
   assign bus.ovf     = ovf_q;

endmodule
